pin_entry_ctrl: RTL

//  Sequences keypad PIN entry for the lock: shifts in 4 hex digits, issues a 1-cycle validPin strobe
//  to the PIN comparator, samples its status, counts failed attempts, enforces a timed lockout.

---
 rtl/pin_pkg.sv | 29 ++
 rtl/pin_cycle_timer.sv | 38 +++
 rtl/pin_entry_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pin_pkg.sv
// Shared types and constants for the keypad PIN entry controller.
// Optional build macro ENTRY_TIMEOUT_EN (used in pin_entry_ctrl) aborts an idle partial entry.
package pin_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_VERIFY,
        S_CHECK,
        S_UNLOCKED,
        S_LOCKOUT
    } pin_state_e;

    localparam int PIN_DIGITS = 4;
    localparam int PIN_W      = 16;
    localparam int DIGIT_W    = 4;

    // Width of the shared cycle timer; covers the 10 s lockout at 500 Hz with headroom.
    localparam int TMR_W      = 16;

    // Append a digit on the right; the oldest digit ends up in the top nibble.
    function automatic logic [PIN_W-1:0] shift_in_digit(
        input logic [PIN_W-1:0]   pin,
        input logic [DIGIT_W-1:0] d
    );
        return {pin[PIN_W-DIGIT_W-1:0], d};
    endfunction

endpackage

// File: rtl/pin_cycle_timer.sv
// Saturating down-counter: load a limit, count while enabled, done when it reaches zero.
// Shared by the lockout period and the optional idle-entry timeout.
module pin_cycle_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: a load restarts the period, otherwise step down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/pin_entry_ctrl.sv
// Keypad PIN entry sequencer: shifts in 4 hex digits, strobes the external comparator,
// samples its verdict, counts failed attempts and enforces a timed lockout.
// Build option: define ENTRY_TIMEOUT_EN to abort a partial entry after TIMEOUT_CYCLES idle cycles.
// Handshake: digit_valid/btn_enter/btn_clear are 1-cycle pulses with no backpressure; validPin is a
// 1-cycle strobe and verify_status is sampled exactly one cycle after validPin drops (S_CHECK).
module pin_entry_ctrl
    import pin_pkg::*;
#(
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 2500
) (
    input  logic               clk_500Hz,
    input  logic               btnR,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               btn_enter,
    input  logic               btn_clear,
    input  logic               verify_status,
    output logic [PIN_W-1:0]   userPin,
    output logic               validPin,
    output logic               unlocked,
    output logic               locked_out,
    output logic [3:0]         attempts_left,
    output logic [2:0]         digit_count,
    output pin_state_e         state_dbg
);

    localparam logic [3:0]       ATT_MAX       = 4'(MAX_ATTEMPTS);
    localparam logic [2:0]       CNT_FULL      = 3'(PIN_DIGITS);
    // The timer reports done on its last cycle, so load one less than the period length.
    localparam logic [TMR_W-1:0] LOCK_LIMIT    = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

    pin_state_e       state_q, state_d;
    logic [PIN_W-1:0] pin_q, pin_d;
    logic [2:0]       count_q, count_d;
    logic             valid_q, valid_d;
    logic             unlocked_q, unlocked_d;
    logic             lockout_q, lockout_d;
    logic [3:0]       attempts_q, attempts_d;
    // Set when enter was pressed on a short entry: the verdict is forced to "fail".
    logic             short_q, short_d;

    logic             tmr_load;
    logic             tmr_en;
    logic             tmr_done;
    logic [TMR_W-1:0] tmr_load_val;

    // The only load that can target S_LOCKOUT is the lockout period; every other load is the timeout.
    assign tmr_load_val = (state_d == S_LOCKOUT) ? LOCK_LIMIT : TIMEOUT_LIMIT;

    pin_cycle_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk_500Hz),
        .rst      (btnR),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_load_val),
        .done     (tmr_done)
    );

    // Next-state and next-output logic; priority inside S_ENTRY is clear > enter > digit.
    always_comb begin
        state_d    = state_q;
        pin_d      = pin_q;
        count_d    = count_q;
        valid_d    = 1'b0;
        unlocked_d = unlocked_q;
        lockout_d  = lockout_q;
        attempts_d = attempts_q;
        short_d    = short_q;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (digit_valid) begin
                    pin_d   = shift_in_digit(pin_q, digit);
                    count_d = 3'd1;
                    state_d = S_ENTRY;
`ifdef ENTRY_TIMEOUT_EN
                    tmr_load = 1'b1;
`endif
                end
            end

            S_ENTRY: begin
`ifdef ENTRY_TIMEOUT_EN
                tmr_en = 1'b1;
`endif
                if (btn_clear) begin
                    pin_d   = '0;
                    count_d = '0;
                    state_d = S_IDLE;
                end else if (btn_enter) begin
                    // A short entry still walks the verify path so its failure costs the same 3 edges.
                    state_d = S_VERIFY;
                    if (count_q == CNT_FULL) begin
                        valid_d = 1'b1;
                        short_d = 1'b0;
                    end else begin
                        short_d = 1'b1;
                    end
                end else if (digit_valid) begin
                    if (count_q < CNT_FULL) begin
                        pin_d   = shift_in_digit(pin_q, digit);
                        count_d = count_q + 3'd1;
                    end
`ifdef ENTRY_TIMEOUT_EN
                    tmr_load = 1'b1;
`endif
                end
`ifdef ENTRY_TIMEOUT_EN
                else if (tmr_done) begin
                    pin_d   = '0;
                    count_d = '0;
                    state_d = S_IDLE;
                end
`endif
            end

            S_VERIFY: begin
                state_d = S_CHECK;
            end

            S_CHECK: begin
                pin_d   = '0;
                count_d = '0;
                short_d = 1'b0;
                if (verify_status && !short_q) begin
                    state_d    = S_UNLOCKED;
                    unlocked_d = 1'b1;
                    attempts_d = ATT_MAX;
                end else if (attempts_q <= 4'd1) begin
                    state_d    = S_LOCKOUT;
                    lockout_d  = 1'b1;
                    attempts_d = '0;
                    tmr_load   = 1'b1;
                end else begin
                    state_d    = S_IDLE;
                    attempts_d = attempts_q - 4'd1;
                end
            end

            S_UNLOCKED: begin
                if (btn_clear) begin
                    state_d    = S_IDLE;
                    unlocked_d = 1'b0;
                    pin_d      = '0;
                    count_d    = '0;
                end
            end

            S_LOCKOUT: begin
                tmr_en = 1'b1;
                if (tmr_done) begin
                    state_d    = S_IDLE;
                    lockout_d  = 1'b0;
                    attempts_d = ATT_MAX;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset overrides every other input.
    always_ff @(posedge clk_500Hz) begin
        if (btnR) begin
            state_q    <= S_IDLE;
            pin_q      <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            unlocked_q <= 1'b0;
            lockout_q  <= 1'b0;
            attempts_q <= ATT_MAX;
            short_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pin_q      <= pin_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            unlocked_q <= unlocked_d;
            lockout_q  <= lockout_d;
            attempts_q <= attempts_d;
            short_q    <= short_d;
        end
    end

    assign userPin       = pin_q;
    assign validPin      = valid_q;
    assign unlocked      = unlocked_q;
    assign locked_out    = lockout_q;
    assign attempts_left = attempts_q;
    assign digit_count   = count_q;
    assign state_dbg     = state_q;

endmodule
